// File: rtl/pma_region_checker_pkg.sv
// Types and helpers shared by the PMA region checker, its bus interface and its comparators.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pma_region_checker_pkg;

    // Physical address width carried by the rule struct. The checker's PLEN
    // parameter must equal this value, because the rule fields are sized by it.
    localparam int unsigned PMA_PLEN = 56;

    typedef struct packed {
        logic exec;
        logic nonidem;
        logic cacheable;
    } pma_attr_t;

    typedef struct packed {
        logic                en;
        logic [PMA_PLEN-1:0] base;
        logic [PMA_PLEN-1:0] len;
        pma_attr_t           attr;
    } pma_rule_t;

    // True when base <= addr < base+len. The end is computed one bit wider so
    // that a region reaching the top of the address space does not wrap.
    // With len == 0 both bounds coincide, so nothing can match.
    function automatic logic range_check(input logic [PMA_PLEN-1:0] base,
                                         input logic [PMA_PLEN-1:0] len,
                                         input logic [PMA_PLEN-1:0] addr);
        logic [PMA_PLEN:0] lim;
        lim = {1'b0, base} + {1'b0, len};
        return (addr >= base) && ({1'b0, addr} < lim);
    endfunction

endpackage

// File: rtl/pma_region_checker_if.sv
// Bundles the rule-programming, lookup-request and lookup-response signals of the checker.
// Latency: n/a (wires only).
// Backpressure: req is valid/ready, resp is valid/ready.
interface pma_region_checker_if
    import pma_region_checker_pkg::*;
#(
    parameter int unsigned NR_RULES = 16,
    parameter int unsigned PLEN     = PMA_PLEN
) ();
    localparam int unsigned IDX_W = (NR_RULES > 1) ? $clog2(NR_RULES) : 1;

    logic             cfg_we_i;
    logic [IDX_W-1:0] cfg_idx_i;
    pma_rule_t        cfg_rule_i;
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [PLEN-1:0]  req_addr_i;
    logic             resp_valid_o;
    logic             resp_ready_i;
    pma_attr_t        resp_attr_o;
    logic             resp_hit_o;
    logic [IDX_W-1:0] resp_hit_idx_o;

    // The checker itself.
    modport slave (
        input  cfg_we_i, cfg_idx_i, cfg_rule_i, flush_i,
        input  req_valid_i, req_addr_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_attr_o, resp_hit_o, resp_hit_idx_o
    );

    // The requester / rule programmer.
    modport master (
        output cfg_we_i, cfg_idx_i, cfg_rule_i, flush_i,
        output req_valid_i, req_addr_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_attr_o, resp_hit_o, resp_hit_idx_o
    );
endinterface

// File: rtl/pma_region_checker_rule_match.sv
// Single-rule comparator: flags whether an enabled rule covers the address and forwards its attributes.
// Latency: combinational.
// Backpressure: none.
module pma_rule_match
    import pma_region_checker_pkg::*;
(
    input  pma_rule_t           rule_i,
    input  logic [PMA_PLEN-1:0] addr_i,
    output logic                pass_o,
    output pma_attr_t           attr_o
);
    // Disabled rules never pass, whatever their range holds.
    always_comb begin
        pass_o = rule_i.en && range_check(rule_i.base, rule_i.len, addr_i);
        attr_o = rule_i.attr;
    end
endmodule

// File: rtl/pma_region_checker.sv
// Programmable PMA table with a 2-stage lookup: S1 samples per-rule matches, S2 reduces them to attrs/hit/index.
// Latency: accept in cycle N gives resp_valid_o in N+2; one lookup per cycle.
// Backpressure: resp stall holds S2 and then S1; req_ready_o drops once both are occupied and S2 cannot drain.
module pma_region_checker
    import pma_region_checker_pkg::*;
#(
    parameter int unsigned NR_RULES = 16,
    parameter int unsigned PLEN     = PMA_PLEN
) (
    input logic                clk_i,
    input logic                rst_ni,
    pma_region_checker_if.slave bus
);
    localparam int unsigned     IDX_W      = (NR_RULES > 1) ? $clog2(NR_RULES) : 1;
    localparam logic [IDX_W:0] NR_RULES_L = (IDX_W + 1)'(NR_RULES);

    pma_rule_t           rules_q [NR_RULES];
    pma_rule_t           rules_d [NR_RULES];
    logic [NR_RULES-1:0] pass;
    logic [NR_RULES-1:0] en_vec;
    pma_attr_t           attr_c  [NR_RULES];

    logic                s1_valid_q, s1_valid_d;
    logic [NR_RULES-1:0] s1_pass_q, s1_pass_d;
    pma_attr_t           s1_attr_q [NR_RULES];
    pma_attr_t           s1_attr_d [NR_RULES];
    logic                s1_dflt_exec_q, s1_dflt_exec_d;

    logic                s2_valid_q, s2_valid_d;
    pma_attr_t           s2_attr_q, s2_attr_d;
    logic                s2_hit_q, s2_hit_d;
    logic [IDX_W-1:0]    s2_idx_q, s2_idx_d;

    logic                s2_adv;
    logic                req_ready;
    logic                accept;
    pma_attr_t           red_attr;
    logic [IDX_W-1:0]    red_idx;

    // One comparator per rule slot, all looking at the incoming request address.
    for (genvar k = 0; k < NR_RULES; k++) begin : g_match
        pma_rule_match u_match (
            .rule_i (rules_q[k]),
            .addr_i (bus.req_addr_i),
            .pass_o (pass[k]),
            .attr_o (attr_c[k])
        );
        assign en_vec[k] = rules_q[k].en;
    end

    // Handshake: S2 drains on consumer ready, S1 moves whenever S2 can take it.
    always_comb begin
        s2_adv    = !s2_valid_q || bus.resp_ready_i;
        req_ready = !s1_valid_q || s2_adv;
        accept    = bus.req_valid_i && req_ready;
    end

    // S2 reduction of the sampled match vector: OR of attrs, lowest index wins.
    always_comb begin
        red_attr = '0;
        red_idx  = '0;
        for (int k = NR_RULES - 1; k >= 0; k--) begin
            if (s1_pass_q[k]) begin
                red_idx = IDX_W'(k);
            end
        end
        for (int k = 0; k < NR_RULES; k++) begin
            if (s1_pass_q[k]) begin
                red_attr = red_attr | s1_attr_q[k];
            end
        end
        // An empty table is permissive for instruction fetch.
        if (s1_dflt_exec_q) begin
            red_attr.exec = 1'b1;
        end
    end

    // Next-state for the rule table and both pipeline stages.
    always_comb begin
        rules_d = rules_q;
        if (bus.cfg_we_i && ({1'b0, bus.cfg_idx_i} < NR_RULES_L)) begin
            rules_d[bus.cfg_idx_i] = bus.cfg_rule_i;
        end

        s1_valid_d     = s1_valid_q;
        s1_pass_d      = s1_pass_q;
        s1_attr_d      = s1_attr_q;
        s1_dflt_exec_d = s1_dflt_exec_q;
        s2_valid_d     = s2_valid_q;
        s2_attr_d      = s2_attr_q;
        s2_hit_d       = s2_hit_q;
        s2_idx_d       = s2_idx_q;

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_attr_d = red_attr;
                s2_hit_d  = |s1_pass_q;
                s2_idx_d  = red_idx;
            end
        end

        if (req_ready) begin
            s1_valid_d = bus.req_valid_i;
        end
        // Attributes are snapshotted with the match vector so later table
        // writes cannot change a lookup already in flight.
        if (accept) begin
            s1_pass_d      = pass;
            s1_attr_d      = attr_c;
            s1_dflt_exec_d = ~|en_vec;
        end

        if (bus.flush_i) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    // State registers; reset clears the table and drops any in-flight lookup.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < NR_RULES; k++) begin
                rules_q[k]   <= '0;
                s1_attr_q[k] <= '0;
            end
            s1_valid_q     <= 1'b0;
            s1_pass_q      <= '0;
            s1_dflt_exec_q <= 1'b0;
            s2_valid_q     <= 1'b0;
            s2_attr_q      <= '0;
            s2_hit_q       <= 1'b0;
            s2_idx_q       <= '0;
        end else begin
            rules_q        <= rules_d;
            s1_attr_q      <= s1_attr_d;
            s1_valid_q     <= s1_valid_d;
            s1_pass_q      <= s1_pass_d;
            s1_dflt_exec_q <= s1_dflt_exec_d;
            s2_valid_q     <= s2_valid_d;
            s2_attr_q      <= s2_attr_d;
            s2_hit_q       <= s2_hit_d;
            s2_idx_q       <= s2_idx_d;
        end
    end

    assign bus.req_ready_o    = req_ready;
    assign bus.resp_valid_o   = s2_valid_q;
    assign bus.resp_attr_o    = s2_attr_q;
    assign bus.resp_hit_o     = s2_hit_q;
    assign bus.resp_hit_idx_o = s2_idx_q;

endmodule

// File: tb/tb_pma_region_checker.sv
// Directed bench for pma_region_checker: table programming, matching, priority, stall, flush, reset.
// Latency: n/a.
// Backpressure: drives resp_ready_i low in the stall and flush sections.
module tb_pma_region_checker;
    import pma_region_checker_pkg::*;

    localparam logic [55:0] TOP_BASE = 56'hFF_FFFF_FFFF_F000;
    localparam logic [55:0] ALL_ONES = 56'hFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    pma_region_checker_if #(.NR_RULES(16), .PLEN(56)) bus ();

    pma_region_checker #(.NR_RULES(16), .PLEN(56)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; the write lands on the next edge.
    task automatic write_rule(input logic [3:0] idx, input logic en, input logic [55:0] base,
                              input logic [55:0] len, input logic [2:0] attr);
        bus.cfg_we_i   = 1'b1;
        bus.cfg_idx_i  = idx;
        bus.cfg_rule_i = {en, base, len, attr};
        @(posedge clk); #1;
        bus.cfg_we_i   = 1'b0;
    endtask

    // Single lookup on an empty pipe with the consumer ready; checks latency and result.
    task automatic lookup_chk(input string tag, input logic [55:0] a, input logic eh,
                              input logic [3:0] ei, input logic [2:0] ea);
        bus.resp_ready_i = 1'b1;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = a;
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk({tag, "_vld_n1"}, 64'(bus.resp_valid_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, "_vld_n2"}, 64'(bus.resp_valid_o), 64'd1);
        chk({tag, "_hit"}, 64'(bus.resp_hit_o), 64'(eh));
        chk({tag, "_idx"}, 64'(bus.resp_hit_idx_o), 64'(ei));
        chk({tag, "_attr"}, 64'(bus.resp_attr_o), 64'(ea));
        @(posedge clk); #1;
    endtask

    logic [55:0] s_addr [4];
    logic        s_hit  [4];
    logic [3:0]  s_idx  [4];
    logic [2:0]  s_attr [4];
    int          req_i;
    int          resp_i;
    int          stale;
    logic        acc;

    initial begin
        rst_n            = 1'b0;
        bus.cfg_we_i     = 1'b0;
        bus.cfg_idx_i    = '0;
        bus.cfg_rule_i   = '0;
        bus.flush_i      = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.resp_ready_i = 1'b1;

        // Reset state.
        #12;
        chk("rst_vld",  64'(bus.resp_valid_o),   64'd0);
        chk("rst_attr", 64'(bus.resp_attr_o),    64'd0);
        chk("rst_hit",  64'(bus.resp_hit_o),     64'd0);
        chk("rst_idx",  64'(bus.resp_hit_idx_o), 64'd0);
        chk("rst_rdy",  64'(bus.req_ready_o),    64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty table: permissive exec, no hit.
        lookup_chk("empty", 56'h8000_0000, 1'b0, 4'd0, 3'b100);

        // Single rule, last byte inside and first byte past the end.
        write_rule(4'd3, 1'b1, 56'h1000_0000, 56'h1000, 3'b010);
        lookup_chk("r3_in",  56'h1000_0FFF, 1'b1, 4'd3, 3'b010);
        lookup_chk("r3_out", 56'h1000_1000, 1'b0, 4'd0, 3'b000);

        // Overlap: lowest index reported, attributes ORed.
        write_rule(4'd2, 1'b1, 56'h2000, 56'h1000, 3'b101);
        write_rule(4'd5, 1'b1, 56'h1000, 56'h2000, 3'b010);
        lookup_chk("overlap", 56'h2000, 1'b1, 4'd2, 3'b111);

        // Region ending exactly at the top of the address space.
        write_rule(4'd7, 1'b1, TOP_BASE, 56'h1000, 3'b001);
        lookup_chk("top", ALL_ONES, 1'b1, 4'd7, 3'b001);

        // Enabled zero-length rule never matches.
        write_rule(4'd8, 1'b1, 56'h5000, 56'h0, 3'b111);
        lookup_chk("len0", 56'h5000, 1'b0, 4'd0, 3'b000);

        // Back-to-back stream with a 3-cycle consumer stall.
        s_addr[0] = 56'h1000_0000; s_hit[0] = 1'b1; s_idx[0] = 4'd3; s_attr[0] = 3'b010;
        s_addr[1] = 56'h2000;      s_hit[1] = 1'b1; s_idx[1] = 4'd2; s_attr[1] = 3'b111;
        s_addr[2] = 56'h8000_0000; s_hit[2] = 1'b0; s_idx[2] = 4'd0; s_attr[2] = 3'b000;
        s_addr[3] = ALL_ONES;      s_hit[3] = 1'b1; s_idx[3] = 4'd7; s_attr[3] = 3'b001;
        bus.resp_ready_i = 1'b0;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = s_addr[0];
        @(posedge clk); #1;
        bus.req_addr_i = s_addr[1];
        @(negedge clk);
        chk("strm_rdy_one_held", 64'(bus.req_ready_o), 64'd1);
        @(posedge clk); #1;
        bus.req_addr_i = s_addr[2];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_rdy",  64'(bus.req_ready_o),    64'd0);
            chk("stall_vld",  64'(bus.resp_valid_o),   64'd1);
            chk("stall_hit",  64'(bus.resp_hit_o),     64'(s_hit[0]));
            chk("stall_idx",  64'(bus.resp_hit_idx_o), 64'(s_idx[0]));
            chk("stall_attr", 64'(bus.resp_attr_o),    64'(s_attr[0]));
            @(posedge clk); #1;
        end
        bus.resp_ready_i = 1'b1;
        req_i  = 2;
        resp_i = 0;
        for (int c = 0; c < 20 && resp_i < 4; c++) begin
            @(negedge clk);
            if (bus.resp_valid_o && bus.resp_ready_i) begin
                chk("strm_hit",  64'(bus.resp_hit_o),     64'(s_hit[resp_i]));
                chk("strm_idx",  64'(bus.resp_hit_idx_o), 64'(s_idx[resp_i]));
                chk("strm_attr", 64'(bus.resp_attr_o),    64'(s_attr[resp_i]));
                resp_i++;
            end
            acc = bus.req_valid_i && bus.req_ready_o;
            @(posedge clk); #1;
            if (acc) begin
                req_i++;
                if (req_i < 4) bus.req_addr_i = s_addr[req_i];
                else           bus.req_valid_i = 1'b0;
            end
        end
        bus.req_valid_i = 1'b0;
        chk("strm_count", 64'(resp_i), 64'd4);
        @(posedge clk); #1;

        // Write and lookup of the same slot in one cycle: the lookup sees the old rule.
        bus.resp_ready_i = 1'b1;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = 56'h8000_0000;
        write_rule(4'd0, 1'b1, 56'h8000_0000, 56'h1000, 3'b100);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("wr_same_vld_n1", 64'(bus.resp_valid_o), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("wr_same_vld",  64'(bus.resp_valid_o), 64'd1);
        chk("wr_same_hit",  64'(bus.resp_hit_o),   64'd0);
        chk("wr_same_attr", 64'(bus.resp_attr_o),  64'd0);
        @(posedge clk); #1;
        lookup_chk("wr_after", 56'h8000_0000, 1'b1, 4'd0, 3'b100);

        // Flush with two lookups held, then a flush coinciding with an accept.
        bus.resp_ready_i = 1'b0;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = 56'h8000_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(negedge clk);
        chk("fl_pre_vld", 64'(bus.resp_valid_o), 64'd1);
        chk("fl_pre_rdy", 64'(bus.req_ready_o),  64'd0);
        bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b1;
        @(negedge clk);
        chk("fl_vld", 64'(bus.resp_valid_o), 64'd0);
        chk("fl_rdy", 64'(bus.req_ready_o),  64'd1);
        @(posedge clk); #1;
        bus.flush_i      = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.resp_ready_i = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (bus.resp_valid_o) stale++;
            @(posedge clk); #1;
        end
        chk("fl_stale", 64'(stale), 64'd0);

        // Asynchronous reset mid-operation drops a held response and clears the table.
        bus.resp_ready_i = 1'b0;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = 56'h1000_0000;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        @(posedge clk); #1;
        chk("ar_pre_vld", 64'(bus.resp_valid_o), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(bus.resp_valid_o), 64'd0);
        chk("ar_hit", 64'(bus.resp_hit_o),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        lookup_chk("ar_cleared", 56'h1000_0000, 1'b0, 4'd0, 3'b100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute guard against a hung run.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
